// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The state enum is also used to decode the debug state output.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_KILL  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] WORD_BYTES       = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding {instr, pc} for a word that returns while
// the decode stage is stalled and the output slot is still occupied.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        drain,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic        full,
  output logic [31:0] instr_q,
  output logic [31:0] pc_q
);

  logic        r_full;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  // Flush wins over load so a redirect never leaves a stale entry behind.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_full <= 1'b0;
    end else if (load) begin
      r_full <= 1'b1;
    end else if (drain) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= '0;
      r_pc    <= '0;
    end else if (load) begin
      r_instr <= instr_in;
      r_pc    <= pc_in;
    end
  end

  assign full    = r_full;
  assign instr_q = r_instr;
  assign pc_q    = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, requests words from instruction
// memory and presents a registered instruction with its PC to decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic [1:0]  dbg_state
);

  // Handshakes: a memory word transfers on a cycle with imem_req=1 and
  // imem_ready=1, and imem_addr never changes while imem_req=1 waits for
  // imem_ready. The decode stage takes instr_out on a cycle with
  // instr_valid=1 and stall_id=0; with stall_id=1 the outputs are held.

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_pending;
  logic [31:0]  w_pending_nxt;
  logic         r_valid;
  logic         w_valid_nxt;
  logic [31:0]  r_instr;
  logic [31:0]  w_instr_nxt;
  logic [31:0]  r_pc_out;
  logic [31:0]  w_pc_out_nxt;
  logic [31:0]  r_pc4_out;
  logic [31:0]  w_pc4_out_nxt;
  logic         w_req;
  logic         w_skid_load;
  logic         w_skid_drain;
  logic         w_skid_flush;
  logic         w_skid_full;
  logic [31:0]  w_skid_instr;
  logic [31:0]  w_skid_pc;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_inc;
  logic         w_slot_free;

  assign w_target    = word_align(redirect_pc);
  assign w_pc_inc    = r_pc + WORD_BYTES;
  assign w_slot_free = !r_valid || !stall_id;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (w_skid_load),
    .drain    (w_skid_drain),
    .flush    (w_skid_flush),
    .instr_in (imem_rdata),
    .pc_in    (r_pc),
    .full     (w_skid_full),
    .instr_q  (w_skid_instr),
    .pc_q     (w_skid_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RST;
      r_pc      <= word_align(RESET_PC);
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_pc_out  <= '0;
      r_pc4_out <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pending <= w_pending_nxt;
      r_valid   <= w_valid_nxt;
      r_instr   <= w_instr_nxt;
      r_pc_out  <= w_pc_out_nxt;
      r_pc4_out <= w_pc4_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pending_nxt = r_pending;
    w_valid_nxt   = r_valid;
    w_instr_nxt   = r_instr;
    w_pc_out_nxt  = r_pc_out;
    w_pc4_out_nxt = r_pc4_out;
    w_req         = 1'b0;
    w_skid_load   = 1'b0;
    w_skid_drain  = 1'b0;
    w_skid_flush  = 1'b0;

    case (r_state)
      ST_RST: begin
        w_valid_nxt   = 1'b0;
        w_instr_nxt   = '0;
        w_pc_out_nxt  = '0;
        w_pc4_out_nxt = '0;
        w_pc_nxt      = redirect_valid ? w_target : word_align(RESET_PC);
        w_state_nxt   = ST_FETCH;
      end

      ST_FETCH: begin
        w_req = 1'b1;
        if (redirect_valid) begin
          w_valid_nxt  = 1'b0;
          w_skid_flush = 1'b1;
          if (imem_ready) begin
            w_pc_nxt = w_target;
          end else begin
            // Address must stay put until the stale request completes.
            w_pending_nxt = w_target;
            w_state_nxt   = ST_KILL;
          end
        end else if (imem_ready) begin
          if (w_slot_free) begin
            w_valid_nxt   = 1'b1;
            w_instr_nxt   = imem_rdata;
            w_pc_out_nxt  = r_pc;
            w_pc4_out_nxt = w_pc_inc;
            w_pc_nxt      = w_pc_inc;
          end else begin
            w_skid_load = 1'b1;
            w_state_nxt = ST_HOLD;
          end
        end else if (!stall_id) begin
          w_valid_nxt = 1'b0;
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          w_valid_nxt  = 1'b0;
          w_skid_flush = 1'b1;
          w_pc_nxt     = w_target;
          w_state_nxt  = ST_FETCH;
        end else if (!stall_id && w_skid_full) begin
          w_skid_drain  = 1'b1;
          w_valid_nxt   = 1'b1;
          w_instr_nxt   = w_skid_instr;
          w_pc_out_nxt  = w_skid_pc;
          w_pc4_out_nxt = w_skid_pc + WORD_BYTES;
          w_pc_nxt      = w_pc_inc;
          w_state_nxt   = ST_FETCH;
        end else if (!stall_id) begin
          w_state_nxt = ST_FETCH;
        end
      end

      ST_KILL: begin
        w_req       = 1'b1;
        w_valid_nxt = 1'b0;
        if (redirect_valid) begin
          w_skid_flush = 1'b1;
          if (imem_ready) begin
            w_pc_nxt    = w_target;
            w_state_nxt = ST_FETCH;
          end else begin
            w_pending_nxt = w_target;
          end
        end else if (imem_ready) begin
          w_pc_nxt    = r_pending;
          w_state_nxt = ST_FETCH;
        end
      end

      default: begin
        w_state_nxt = ST_RST;
      end
    endcase
  end

  assign imem_req     = w_req;
  assign imem_addr    = r_pc;
  assign instr_valid  = r_valid;
  assign instr_out    = r_instr;
  assign pc_out       = r_pc_out;
  assign pc_plus4_out = r_pc4_out;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model, program-order model,
// protocol monitor and directed scenarios with literal expectations.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] data_xor = 32'h0;
  int          mem_lat  = 0;
  bit          mem_manual = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] exp_pc   = RESET_PC;
  logic [31:0] exp_q[$];

  logic        p_rst = 1'b0;
  logic        p_req = 1'b0;
  logic        p_rdy = 1'b0;
  logic        p_redir = 1'b0;
  logic        p_valid = 1'b0;
  logic        p_stall = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_instr = '0;
  logic [31:0] p_pco = '0;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .pc_plus4_out   (pc_plus4_out),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ data_xor;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [31:0] xr, input int lat);
    reset          = 1'b1;
    stall_id       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_manual     = 1'b0;
    data_xor       = xr;
    mem_lat        = lat;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_out(input logic [31:0] pc, input int budget);
    int n = 0;
    while (!(instr_valid && pc_out == pc) && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (!(instr_valid && pc_out == pc)) begin
      n_fail++;
      $display("FAIL wait_out: actual pc_out=%h valid=%0d required pc_out=%h valid=1",
               pc_out, instr_valid, pc);
    end
  endtask

  // ---------------- memory model ----------------
  always @(posedge clk) begin
    #1;
    if (mem_manual) begin
      wait_cnt = 0;
    end else if (imem_req) begin
      if (wait_cnt >= mem_lat) begin
        imem_ready = 1'b1;
        imem_rdata = word_of(imem_addr);
        wait_cnt   = 0;
      end else begin
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        wait_cnt++;
      end
    end else begin
      imem_ready = 1'b0;
      wait_cnt   = 0;
    end
  end

  // ---------------- compare process: program-order model + protocol ----------------
  always @(negedge clk) begin
    if (p_rst) begin
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr_out, 32'h0);
      chk("rst_pc", pc_out, 32'h0);
      chk("rst_pc4", pc_plus4_out, 32'h0);
    end else begin
      if (imem_req) chk("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
      if (p_req && !p_rdy) begin
        chk("req_held", imem_req, 1'b1);
        chk("addr_held", imem_addr, p_addr);
      end
      if (p_redir) chk("flush_valid", instr_valid, 1'b0);
      if (p_valid && p_stall && !p_redir) begin
        chk("stall_valid", instr_valid, 1'b1);
        chk("stall_instr", instr_out, p_instr);
        chk("stall_pc", pc_out, p_pco);
      end
    end
    if (instr_valid && !stall_id && !redirect_valid && !reset) begin
      chk("order_pc", pc_out, exp_pc);
      chk("order_instr", instr_out, word_of(exp_pc));
      chk("order_pc4", pc_plus4_out, exp_pc + 32'd4);
      if (exp_q.size() > 0) chk("sb_pc", pc_out, exp_q.pop_front());
      exp_pc = exp_pc + 32'd4;
    end
    if (reset) exp_pc = RESET_PC;
    else if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
    p_rst   = reset;
    p_req   = imem_req;
    p_rdy   = imem_ready;
    p_redir = redirect_valid;
    p_valid = instr_valid;
    p_stall = stall_id;
    p_addr  = imem_addr;
    p_instr = instr_out;
    p_pco   = pc_out;
  end

  // ---------------- directed scenarios ----------------
  initial begin
    reset = 1'b1; stall_id = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ready = 1'b0; imem_rdata = '0;

    // Sequential fetch, zero-wait memory returning the address as data.
    do_reset(32'h0, 0);
    chk("p1_rst_req", imem_req, 1'b0);
    step();
    chk("p1_req", imem_req, 1'b1);
    chk("p1_addr0", imem_addr, 32'h0);
    chk("p1_not_yet", instr_valid, 1'b0);
    step();
    chk("p1_first_valid", instr_valid, 1'b1);
    chk("p1_first_pc", pc_out, 32'h0);
    chk("p1_first_pc4", pc_plus4_out, 32'h4);
    chk("p1_addr4", imem_addr, 32'h4);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("p1_seq_pc", pc_out, 32'(4 * k));
      chk("p1_seq_instr", instr_out, 32'(4 * k));
      chk("p1_seq_addr", imem_addr, 32'(4 * k + 4));
    end

    // Three cycles per memory response.
    do_reset(32'hC0DE_0000, 2);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("p2_wait_addr", imem_addr, 32'h0);
      chk("p2_wait_valid", instr_valid, 1'b0);
      step();
    end
    chk("p2_valid", instr_valid, 1'b1);
    chk("p2_instr", instr_out, 32'hC0DE_0000);
    step();
    chk("p2_once", instr_valid, 1'b0);
    wait_out(32'h4, 10);
    wait_out(32'h8, 10);

    // Stall at PC 8 for four cycles with the next word in the skid buffer.
    do_reset(32'hC0DE_0000, 0);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    wait_out(32'h8, 10);
    stall_id = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("p3_hold_pc", pc_out, 32'h8);
      chk("p3_hold_instr", instr_out, 32'hC0DE_0008);
      chk("p3_no_req", imem_req, 1'b0);
    end
    stall_id = 1'b0;
    step();
    chk("p3_skid_pc", pc_out, 32'hC);
    chk("p3_skid_valid", instr_valid, 1'b1);
    step();
    chk("p3_next_pc", pc_out, 32'h10);
    step();
    chk("p3_sb_drained", exp_q.size(), 0);

    // Redirect to 0x40 while the request for 0x10 waits on memory.
    do_reset(32'hC0DE_0000, 2);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'h40};
    wait_out(32'hC, 40);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("p4_kill_valid", instr_valid, 1'b0);
    chk("p4_kill_addr", imem_addr, 32'h10);
    step();
    chk("p4_kill_addr2", imem_addr, 32'h10);
    step();
    chk("p4_new_addr", imem_addr, 32'h40);
    chk("p4_new_valid", instr_valid, 1'b0);
    wait_out(32'h40, 10);
    step();
    chk("p4_sb_drained", exp_q.size(), 0);

    // Redirect to 0x103 (aligned to 0x100) while holding a skid entry.
    do_reset(32'hC0DE_0000, 0);
    exp_q = '{32'h0, 32'h4, 32'h100, 32'h104};
    wait_out(32'h8, 10);
    stall_id = 1'b1;
    step();
    chk("p5_hold_req", imem_req, 1'b0);
    step();
    chk("p5_hold_pc", pc_out, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step();
    redirect_valid = 1'b0;
    stall_id       = 1'b0;
    chk("p5_flush_valid", instr_valid, 1'b0);
    chk("p5_addr", imem_addr, 32'h100);
    step();
    chk("p5_pc", pc_out, 32'h100);
    chk("p5_pc4", pc_plus4_out, 32'h104);
    chk("p5_instr", instr_out, 32'hC0DE_0100);
    step();
    chk("p5_after_pc", pc_out, 32'h104);
    step();
    chk("p5_sb_drained", exp_q.size(), 0);

    // Reset while the request for 0xC is outstanding; late ready is ignored.
    do_reset(32'hC0DE_0000, 0);
    wait_out(32'h8, 10);
    mem_manual = 1'b1;
    imem_ready = 1'b0;
    step();
    chk("p6_req_out", imem_req, 1'b1);
    chk("p6_addr_c", imem_addr, 32'hC);
    reset = 1'b1;
    step();
    reset      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    chk("p6_req_drop", imem_req, 1'b0);
    chk("p6_valid0", instr_valid, 1'b0);
    step();
    chk("p6_restart_addr", imem_addr, RESET_PC);
    chk("p6_restart_valid", instr_valid, 1'b0);
    imem_ready = 1'b1;
    imem_rdata = 32'hC0DE_0000;
    mem_manual = 1'b0;
    step();
    chk("p6_first_pc", pc_out, RESET_PC);
    chk("p6_first_instr", instr_out, 32'hC0DE_0000);

    // Redirect with memory ready, then wrap past 0xFFFF_FFFC.
    do_reset(32'hC0DE_0000, 0);
    wait_out(32'h4, 10);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    chk("p7_req_target", imem_addr, 32'hFFFF_FFF8);
    chk("p7_flush", instr_valid, 1'b0);
    step();
    chk("p7_pc_fff8", pc_out, 32'hFFFF_FFF8);
    chk("p7_valid", instr_valid, 1'b1);
    step();
    chk("p7_pc_fffc", pc_out, 32'hFFFF_FFFC);
    chk("p7_pc4_wrap", pc_plus4_out, 32'h0);
    step();
    chk("p7_pc_wrap", pc_out, 32'h0);
    chk("p7_instr_wrap", instr_out, 32'hC0DE_0000);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
